uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated receive FIFO and sticky error flags. It is the next-generation serial input for the Hack computer: it replaces the fixed 8N1 single-byte receiver. It sits between the board serial pin and the memory-mapped I/O decode, and the CPU reads buffered characters at its own pace. Frame length, parity, stop bits, baud divisor and buffer depth are all set by parameters.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit (50 MHz / 9600); minimum 4.
DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits (1 or 2).
FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
i_CLK  in  1  system clock; all state changes on the rising edge.
i_RESET  in  1  reset, asynchronous, active-high.
i_Serial_RX  in  1  asynchronous serial line; idle level is high.
i_RD_EN  in  1  pop the FIFO head; ignored when the FIFO is empty.
i_CLR_ERR  in  1  clear all sticky error flags.
o_DATA  out  DATA_BITS  FIFO head (first-word fall-through); valid while o_EMPTY=0.
o_EMPTY  out  1  FIFO empty.
o_FULL  out  1  FIFO full.
o_COUNT  out  $clog2(FIFO_DEPTH)+1  current number of stored entries.
o_FRAME_ERR  out  1  sticky: a stop bit was sampled low.
o_PARITY_ERR  out  1  sticky: parity mismatch.
o_OVERRUN  out  1  sticky: a good frame was dropped because the FIFO was full.

Behaviour:
- Reset values: o_DATA=0, o_EMPTY=1, o_FULL=0, o_COUNT=0, all error flags 0, FSM in IDLE, synchroniser stages at 1. Reset aborts any frame in progress and flushes the FIFO.
- i_Serial_RX passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reloaded on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s=0 -> go to START.
- START: at count CLKS_PER_BIT/2 (integer division), sample rx_s.
  - rx_s=1 -> glitch; return to IDLE with nothing pushed and no flag set.
  - rx_s=0 -> go to DATA.
- DATA: sample every CLKS_PER_BIT clocks, at mid-bit. Shift right into a DATA_BITS register, LSB first. After DATA_BITS samples -> go to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: one sample. Expected bit is XOR of the data bits, inverted for odd parity. A mismatch marks the frame as bad-parity.
- STOP: take STOP_BITS samples, CLKS_PER_BIT apart. Any sample = 0 marks the frame as bad-frame. The frame completes on the cycle of the last stop sample, which is mid-bit.
  - Good frame: push to the FIFO in that cycle.
  - Bad-parity frame: set o_PARITY_ERR; no push.
  - Bad-frame frame: set o_FRAME_ERR; no push. If the last stop sample was 0, go to BREAK; otherwise go to IDLE.
  - Good frame: go to IDLE.
- BREAK: wait for rx_s=1, then go to IDLE. A long low line produces exactly one frame error.
- Latency: o_EMPTY falls one clock after the final stop-bit sample. o_DATA is valid in that same cycle.
- FIFO: circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a separate count register. o_EMPTY = (count==0). o_FULL = (count==FIFO_DEPTH).
- Push while full, no pop in the same cycle: byte is dropped, o_OVERRUN=1, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Allowed when not empty; count is unchanged.
  - When full, the pop frees the slot first, so the push is accepted and o_OVERRUN is not set.
  - When empty, only the push occurs.
- Pop when empty: no effect; pointers and count are unchanged.
- Sticky flags: cleared by i_CLR_ERR. If a new error and i_CLR_ERR occur in the same cycle, the flag ends set.

Test Plan:
- 8N1 (defaults), send 0x41 then 0x42, no reads -> after the second stop bit o_COUNT=2, o_DATA=0x41. Pulse i_RD_EN -> o_DATA=0x42, o_COUNT=1. Pulse again -> o_EMPTY=1. No error flags set.
- Low pulse of CLKS_PER_BIT/4 on an idle line -> FSM returns to IDLE, o_EMPTY stays 1, no flags. A following valid 0x0D is received correctly.
- PARITY=2, send 0x41 with the parity bit forced to 1 -> o_PARITY_ERR=1, o_COUNT=0. Then send 0x41 with parity 0 -> pushed. Pulse i_CLR_ERR -> flag is 0.
- Send 0x55 with the stop bit held low for 3 bit times -> exactly one o_FRAME_ERR, nothing pushed. After the line returns high, 0x0D is received normally.
- FIFO_DEPTH=4, send 0x01..0x05 with no reads -> o_FULL=1, o_COUNT=4, o_OVERRUN=1, reads return 0x01..0x04. Repeat with a pop on the same cycle as the 5th push -> o_OVERRUN stays 0 and 0x05 is read last.
- Assert i_RESET midway through the data bits of a frame with 2 entries stored -> o_EMPTY=1, o_COUNT=0, all flags 0. The next complete frame, 0x7E, is received and read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_fifo                                                  |
// | Purpose  : UART receiver with configurable frame format feeding a        |
// |            first-word-fall-through receive FIFO, plus sticky frame,      |
// |            parity and overrun error flags.                               |
// | Ports    : i_CLK         system clock, rising edge                       |
// |            i_RESET       asynchronous active-high reset                  |
// |            i_Serial_RX   serial line, idle high                          |
// |            i_RD_EN       pop FIFO head (ignored when empty)              |
// |            i_CLR_ERR     clear all sticky error flags                    |
// |            o_DATA        FIFO head, valid while o_EMPTY=0                |
// |            o_EMPTY       FIFO empty                                      |
// |            o_FULL        FIFO full                                       |
// |            o_COUNT       number of stored entries                        |
// |            o_FRAME_ERR   sticky: a stop bit was sampled low              |
// |            o_PARITY_ERR  sticky: parity mismatch                         |
// |            o_OVERRUN     sticky: good frame dropped, FIFO full           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          i_CLK,
   input  logic                          i_RESET,
   input  logic                          i_Serial_RX,
   input  logic                          i_RD_EN,
   input  logic                          i_CLR_ERR,
   output logic [DATA_BITS-1:0]          o_DATA,
   output logic                          o_EMPTY,
   output logic                          o_FULL,
   output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
   output logic                          o_FRAME_ERR,
   output logic                          o_PARITY_ERR,
   output logic                          o_OVERRUN
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = 4;

   localparam logic [CW-1:0] c_HALF_BIT  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] c_LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
   localparam logic [BW-1:0] c_DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] c_STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] c_BIT_ONE   = BW'(1);
   localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
   localparam logic [AW:0]   c_FIFO_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   c_DEPTH     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   // ---------------------------------------------------------------- sync
   logic sync1_q, rx_s_q;

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= i_Serial_RX;
         rx_s_q  <= sync1_q;
      end
   end

   // ---------------------------------------------------------------- FSM
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 frm_bad_q, frm_bad_d;
   logic                 w_tick, w_par_exp, w_frm_bad_now;
   logic                 w_push, w_set_fe, w_set_pe;

   // Full-bit-period tick: counter is reloaded on state entry, so in the
   // DATA/PARITY/STOP states this lands exactly one bit after the previous
   // mid-bit sample.
   assign w_tick        = (cnt_q == c_LAST_CNT);
   assign w_par_exp     = (^shift_q) ^ (PARITY == 1);
   assign w_frm_bad_now = frm_bad_q | ~rx_s_q;

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      frm_bad_d = frm_bad_q;
      w_push    = 1'b0;
      w_set_fe  = 1'b0;
      w_set_pe  = 1'b0;
      cnt_d     = cnt_q + c_CNT_ONE;

      case (state_q)
         ST_IDLE: begin
            bit_d     = '0;
            par_bad_d = 1'b0;
            frm_bad_d = 1'b0;
            if (!rx_s_q) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == c_HALF_BIT) state_d = rx_s_q ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (w_tick) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_q == c_DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + c_BIT_ONE;
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               par_bad_d = (rx_s_q != w_par_exp);
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               frm_bad_d = w_frm_bad_now;
               if (bit_q == c_STOP_LAST) begin
                  w_set_fe = w_frm_bad_now;
                  w_set_pe = par_bad_q;
                  w_push   = ~w_frm_bad_now & ~par_bad_q;
                  // A low final stop bit means the line may be held in break;
                  // wait for it to rise so only one frame error is raised.
                  state_d  = rx_s_q ? ST_IDLE : ST_BREAK;
               end else begin
                  bit_d = bit_q + c_BIT_ONE;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d != state_q) || w_tick) cnt_d = '0;
   end

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         frm_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         frm_bad_q <= frm_bad_d;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [AW:0]          count_q, count_d;
   logic                 fe_q, pe_q, ov_q;
   logic                 w_empty, w_full, w_pop, w_wr, w_ovr;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == c_DEPTH);
   assign w_pop   = i_RD_EN & ~w_empty;
   // A simultaneous pop frees a slot first, so a push into a full FIFO
   // is only dropped when no pop accompanies it.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_ovr   = w_push & w_full & ~w_pop;

   always_comb begin
      count_d = count_q;
      if (w_wr && !w_pop)      count_d = count_q + c_FIFO_ONE;
      else if (!w_wr && w_pop) count_d = count_q - c_FIFO_ONE;
   end

   always_ff @(posedge i_CLK) begin
      if (w_wr) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fe_q     <= 1'b0;
         pe_q     <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         if (w_wr)  wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
         if (w_pop) rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
         count_q <= count_d;
         // New errors win over a same-cycle clear.
         fe_q    <= (fe_q & ~i_CLR_ERR) | w_set_fe;
         pe_q    <= (pe_q & ~i_CLR_ERR) | w_set_pe;
         ov_q    <= (ov_q & ~i_CLR_ERR) | w_ovr;
      end
   end

   assign o_DATA       = w_empty ? '0 : mem_q[rd_ptr_q];
   assign o_EMPTY      = w_empty;
   assign o_FULL       = w_full;
   assign o_COUNT      = count_q;
   assign o_FRAME_ERR  = fe_q;
   assign o_PARITY_ERR = pe_q;
   assign o_OVERRUN    = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_fifo                                               |
// | Purpose  : Self-checking bench for uart_rx_fifo (8 data bits, even       |
// |            parity, 2 stop bits, 4-entry FIFO, 8 clocks per bit).         |
// |            A frame-level model schedules each frame's outcome at the     |
// |            cycle of its final stop sample and tracks a queue FIFO.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

   localparam int CLKS  = 8;
   localparam int DB    = 8;
   localparam int PAR   = 2;
   localparam int SB    = 2;
   localparam int DEPTH = 4;
   localparam int NBITS = 1 + DB + 1 + SB;
   // Final stop sample edge, counted from the first edge that sees the start bit:
   // 2 sync stages + IDLE detect, half a bit to the start sample, then one bit
   // per remaining frame bit.
   localparam int LAT   = 3 + CLKS / 2 + (NBITS - 1) * CLKS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic          rd  = 1'b0;
   logic          clr = 1'b0;
   logic [DB-1:0] o_DATA;
   logic          o_EMPTY, o_FULL, o_FRAME_ERR, o_PARITY_ERR, o_OVERRUN;
   logic [2:0]    o_COUNT;

   uart_rx_fifo #(
      .CLKS_PER_BIT(CLKS), .DATA_BITS(DB), .PARITY(PAR),
      .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .i_CLK(clk), .i_RESET(rst), .i_Serial_RX(rx), .i_RD_EN(rd),
      .i_CLR_ERR(clr), .o_DATA(o_DATA), .o_EMPTY(o_EMPTY), .o_FULL(o_FULL),
      .o_COUNT(o_COUNT), .o_FRAME_ERR(o_FRAME_ERR),
      .o_PARITY_ERR(o_PARITY_ERR), .o_OVERRUN(o_OVERRUN)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int            at_cyc;
      logic          push;
      logic          fe;
      logic          pe;
      logic [DB-1:0] data;
   } ev_t;

   ev_t           evq[$];
   logic [DB-1:0] mq[$];
   logic          m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0;
   int            rd_pct = 0, clr_pct = 0, pop_edge = -1, clr_edge = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- model
   always @(posedge clk) begin : p_model
      ev_t  ev;
      logic push, nfe, npe, pop;
      cyc  = cyc + 1;
      push = 1'b0;
      nfe  = 1'b0;
      npe  = 1'b0;
      ev   = '{at_cyc: 0, push: 1'b0, fe: 1'b0, pe: 1'b0, data: '0};
      if (rst) begin
         mq.delete();
         evq.delete();
         m_fe = 1'b0;
         m_pe = 1'b0;
         m_ov = 1'b0;
      end else begin
         if (evq.size() > 0 && evq[0].at_cyc == cyc) begin
            ev   = evq.pop_front();
            push = ev.push;
            nfe  = ev.fe;
            npe  = ev.pe;
         end
         pop = rd && (mq.size() > 0);
         if (clr) begin
            m_fe = 1'b0;
            m_pe = 1'b0;
            m_ov = 1'b0;
         end
         if (nfe) m_fe = 1'b1;
         if (npe) m_pe = 1'b1;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev.data);
            else m_ov = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin : p_compare
      if (rst) begin
         check("rst_empty", 32'(o_EMPTY), 32'd1);
         check("rst_full", 32'(o_FULL), 32'd0);
         check("rst_count", 32'(o_COUNT), 32'd0);
         check("rst_data", 32'(o_DATA), 32'd0);
         check("rst_flags", 32'({o_FRAME_ERR, o_PARITY_ERR, o_OVERRUN}), 32'd0);
      end else begin
         check("empty", 32'(o_EMPTY), 32'(mq.size() == 0));
         check("full", 32'(o_FULL), 32'(mq.size() == DEPTH));
         check("count", 32'(o_COUNT), 32'(mq.size()));
         if (mq.size() > 0) check("data", 32'(o_DATA), 32'(mq[0]));
         check("frame_err", 32'(o_FRAME_ERR), 32'(m_fe));
         check("parity_err", 32'(o_PARITY_ERR), 32'(m_pe));
         check("overrun", 32'(o_OVERRUN), 32'(m_ov));
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick(input logic pin);
      @(posedge clk);
      #2;
      rx  = pin;
      rd  = (pop_edge == cyc + 1) || (int'($urandom_range(99)) < rd_pct);
      clr = (clr_edge == cyc + 1) || (int'($urandom_range(99)) < clr_pct);
   endtask

   task automatic pulse_rd();
      @(posedge clk); #2 rd = 1'b1;
      @(posedge clk); #2 rd = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #2 clr = 1'b1;
      @(posedge clk); #2 clr = 1'b0;
   endtask

   // stops[0] is the first stop bit; extra_low extends a low final stop bit
   task automatic send_frame(input logic [DB-1:0] d, input logic bad_par,
                             input logic [SB-1:0] stops, input int extra_low,
                             input bit pop_last, input bit clr_after, input int gap);
      logic [NBITS-1:0] fb;
      logic             pbit;
      ev_t              ev;
      int               p0;
      pbit = ($countones(d) % 2 == 1) ^ bad_par;   // even parity bit
      fb   = {stops, pbit, d, 1'b0};
      for (int b = 0; b < NBITS; b++) begin
         for (int k = 0; k < CLKS; k++) begin
            tick(fb[b]);
            if (b == 0 && k == 0) begin
               p0        = cyc + 1;
               ev.at_cyc = p0 + LAT;
               ev.fe     = (stops != {SB{1'b1}});
               ev.pe     = ($countones({d, pbit}) % 2) != 0;
               ev.push   = !ev.fe && !ev.pe;
               ev.data   = d;
               evq.push_back(ev);
               if (pop_last)  pop_edge = p0 + LAT;
               if (clr_after) clr_edge = p0 + LAT + 2;
            end
         end
      end
      if (!stops[SB-1]) repeat (extra_low * CLKS) tick(1'b0);
      repeat (gap) tick(1'b1);
      pop_edge = -1;
      clr_edge = -1;
   endtask

   initial begin : p_watchdog
      #3_000_000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : p_stim
      logic [DB-1:0] d;
      logic [SB-1:0] st;
      logic [DB-1:0] pd;
      int            len;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // two back-to-back frames, then read them out
      send_frame(8'h41, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      send_frame(8'h42, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      check("two_count", 32'(o_COUNT), 32'd2);
      check("two_head", 32'(o_DATA), 32'h41);
      pulse_rd();
      check("pop1_head", 32'(o_DATA), 32'h42);
      check("pop1_count", 32'(o_COUNT), 32'd1);
      pulse_rd();
      check("pop2_empty", 32'(o_EMPTY), 32'd1);
      check("pop2_flags", 32'({o_FRAME_ERR, o_PARITY_ERR, o_OVERRUN}), 32'd0);

      // short glitch is rejected, following frame is fine
      repeat (CLKS / 4) tick(1'b0);
      repeat (2 * CLKS) tick(1'b1);
      check("glitch_empty", 32'(o_EMPTY), 32'd1);
      check("glitch_flags", 32'({o_FRAME_ERR, o_PARITY_ERR, o_OVERRUN}), 32'd0);
      send_frame(8'h0D, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      check("after_glitch", 32'(o_DATA), 32'h0D);
      pulse_rd();

      // parity error, then a good frame, then clear
      send_frame(8'h41, 1'b1, 2'b11, 0, 1'b0, 1'b0, 12);
      check("par_err_set", 32'(o_PARITY_ERR), 32'd1);
      check("par_err_count", 32'(o_COUNT), 32'd0);
      send_frame(8'h41, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      check("par_ok_data", 32'(o_DATA), 32'h41);
      pulse_clr();
      check("par_cleared", 32'(o_PARITY_ERR), 32'd0);
      pulse_rd();

      // stop bits low for 3 bit times; flag cleared while the line is still low
      send_frame(8'h55, 1'b0, 2'b00, 1, 1'b0, 1'b1, 12);
      check("break_one_err", 32'(o_FRAME_ERR), 32'd0);
      check("break_count", 32'(o_COUNT), 32'd0);
      send_frame(8'h0D, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      check("after_break", 32'(o_DATA), 32'h0D);
      pulse_rd();

      // overrun: five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 2'b11, 0, 1'b0, 1'b0, 6);
      check("ovr_full", 32'(o_FULL), 32'd1);
      check("ovr_count", 32'(o_COUNT), 32'd4);
      check("ovr_flag", 32'(o_OVERRUN), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check("ovr_read", 32'(o_DATA), 32'(i));
         pulse_rd();
      end
      check("ovr_drained", 32'(o_EMPTY), 32'd1);
      pulse_clr();

      // fifth push coincides with a pop
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 2'b11, 0, 1'b0, 1'b0, 6);
      send_frame(8'h05, 1'b0, 2'b11, 0, 1'b1, 1'b0, 6);
      check("pp_no_ovr", 32'(o_OVERRUN), 32'd0);
      check("pp_count", 32'(o_COUNT), 32'd4);
      for (int i = 2; i <= 5; i++) begin
         check("pp_read", 32'(o_DATA), 32'(i));
         pulse_rd();
      end

      // reset in the middle of a frame with entries and a flag present
      send_frame(8'h99, 1'b1, 2'b11, 0, 1'b0, 1'b0, 6);
      send_frame(8'h11, 1'b0, 2'b11, 0, 1'b0, 1'b0, 6);
      send_frame(8'h22, 1'b0, 2'b11, 0, 1'b0, 1'b0, 6);
      check("pre_rst_count", 32'(o_COUNT), 32'd2);
      check("pre_rst_pe", 32'(o_PARITY_ERR), 32'd1);
      pd = 8'h5A;
      repeat (CLKS) tick(1'b0);
      for (int b = 0; b < 3; b++) repeat (CLKS) tick(pd[b]);
      @(posedge clk);
      #2;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      check("mid_rst_empty", 32'(o_EMPTY), 32'd1);
      check("mid_rst_count", 32'(o_COUNT), 32'd0);
      check("mid_rst_flags", 32'({o_FRAME_ERR, o_PARITY_ERR, o_OVERRUN}), 32'd0);
      repeat (CLKS) tick(1'b1);
      send_frame(8'h7E, 1'b0, 2'b11, 0, 1'b0, 1'b0, 12);
      check("post_rst_data", 32'(o_DATA), 32'h7E);
      pulse_rd();
      check("post_rst_empty", 32'(o_EMPTY), 32'd1);

      // randomized traffic with random reads and clears
      rd_pct  = 30;
      clr_pct = 2;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(9) == 0) begin
            len = 1 + int'($urandom_range(2));
            repeat (len) tick(1'b0);
            repeat (2 * CLKS) tick(1'b1);
         end
         d  = 8'($urandom);
         st = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
         send_frame(d, ($urandom_range(5) == 0), st, int'($urandom_range(2)),
                    1'b0, 1'b0, CLKS / 2 + int'($urandom_range(CLKS)));
      end
      rd_pct  = 0;
      clr_pct = 0;
      @(posedge clk);
      #2 rd = 1'b0;
      clr = 1'b0;
      repeat (DEPTH + 1) pulse_rd();
      check("final_empty", 32'(o_EMPTY), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
